// File: rtl/relu_pkg.sv
// ============================================================================
// Module  : relu_pkg
// Brief   : Shared Q16.16 constants and helpers for the activation datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package relu_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int ACC_W  = 80;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    localparam logic [ACC_W-1:0] ROUND_HALF =
        {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic [PROD_W-1:0] sext_data(input logic [DATA_W-1:0] d);
        return {{(PROD_W-DATA_W){d[DATA_W-1]}}, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/q_round_sat.sv
// ============================================================================
// Module  : q_round_sat
// Brief   : Rounds a Q.32 accumulator half-up to Q16.16 and saturates to DATA_W.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module q_round_sat
    import relu_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] C_MAX_EXT =
        {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] C_MIN_EXT =
        {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

    logic        [ACC_W-1:0] w_biased;
    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_over;
    logic                    w_under;

    assign w_biased  = acc + ROUND_HALF;
    assign w_shifted = $signed(w_biased) >>> FRAC_W;
    assign w_over    = w_shifted > C_MAX_EXT;
    assign w_under   = w_shifted < C_MIN_EXT;

    always_comb begin
        y = w_shifted[DATA_W-1:0];
        if (w_over) begin
            y = SAT_MAX;
        end else if (w_under) begin
            y = SAT_MIN;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dot_accumulate.sv
// ============================================================================
// Module  : dot_accumulate
// Brief   : Streaming Q16.16 multiply-accumulate producing one rounded,
//           saturated dot product per ilast-delimited vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_accumulate
    import relu_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic              ilast,
    input  logic              ivalid,
    output logic              iready,
    output logic [DATA_W-1:0] y,
    output logic              ovalid,
    input  logic              oready
);

    logic              w_stall;
    logic              w_accept;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_rounded;

    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_w;
    logic              r_in_valid;
    logic              r_in_last;

    logic [PROD_W-1:0] r_p;
    logic              r_p_valid;
    logic              r_p_last;

    logic [ACC_W-1:0]  r_acc;
    logic              r_first;
    logic [ACC_W-1:0]  r_s;
    logic              r_s_valid;

    logic [DATA_W-1:0] r_y;
    logic              r_ovalid;

    // A single stall freezes every stage so no beat is lost or duplicated.
    assign w_stall  = r_ovalid & ~oready;
    assign iready   = resetn & ~w_stall;
    assign w_accept = ivalid & iready;

    assign y      = r_y;
    assign ovalid = r_ovalid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x        <= '0;
            r_w        <= '0;
            r_in_valid <= 1'b0;
            r_in_last  <= 1'b0;
        end else if (!w_stall) begin
            r_in_valid <= w_accept;
            r_in_last  <= w_accept & ilast;
            if (w_accept) begin
                r_x <= x;
                r_w <= w;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
        end else if (!w_stall) begin
            r_p_valid <= r_in_valid;
            r_p_last  <= r_in_last;
            if (r_in_valid) begin
                r_p <= $signed(sext_data(r_x)) * $signed(sext_data(r_w));
            end
        end
    end

    assign w_sum = (r_first ? '0 : r_acc) + sext_prod(r_p);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_acc     <= '0;
            r_first   <= 1'b1;
            r_s       <= '0;
            r_s_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s_valid <= 1'b0;
            if (r_p_valid) begin
                if (r_p_last) begin
                    r_s       <= w_sum;
                    r_s_valid <= 1'b1;
                    r_acc     <= '0;
                    r_first   <= 1'b1;
                end else begin
                    r_acc   <= w_sum;
                    r_first <= 1'b0;
                end
            end
        end
    end

    q_round_sat u_round_sat (
        .acc (r_s),
        .y   (w_rounded)
    );

    // Unstalled with ovalid set implies oready, so the old result has gone.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_y      <= '0;
            r_ovalid <= 1'b0;
        end else if (!w_stall) begin
            if (r_s_valid) begin
                r_y      <= w_rounded;
                r_ovalid <= 1'b1;
            end else begin
                r_ovalid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dot_accumulate.sv
// ============================================================================
// Module  : tb_dot_accumulate
// Brief   : Directed self-checking bench for dot_accumulate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_accumulate;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] w = '0;
    logic        ilast = 1'b0;
    logic        ivalid = 1'b0;
    logic        iready;
    logic [31:0] y;
    logic        ovalid;
    logic        oready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dot_accumulate dut (
        .clock  (clock),
        .resetn (resetn),
        .x      (x),
        .w      (w),
        .ilast  (ilast),
        .ivalid (ivalid),
        .iready (iready),
        .y      (y),
        .ovalid (ovalid),
        .oready (oready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic beat(input logic [31:0] xv, input logic [31:0] wv, input logic last);
        x      = xv;
        w      = wv;
        ilast  = last;
        ivalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ivalid = 1'b0;
        ilast  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (ovalid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_ovalid"}, {31'b0, ovalid}, 32'h1);
        check({tag, "_y"}, y, exp);
        @(negedge clock);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_y", y, 32'h0);
        check("rst_ovalid", {31'b0, ovalid}, 32'h0);
        check("rst_iready", {31'b0, iready}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_iready", {31'b0, iready}, 32'h1);

        // Single beat with exact latency: 2.0 * 3.0
        beat(32'h0002_0000, 32'h0003_0000, 1'b1);
        check("lat_k", {31'b0, ovalid}, 32'h0);
        @(negedge clock);
        check("lat_k1", {31'b0, ovalid}, 32'h0);
        @(negedge clock);
        check("lat_k2", {31'b0, ovalid}, 32'h0);
        @(negedge clock);
        check("lat_k3_ovalid", {31'b0, ovalid}, 32'h1);
        check("lat_k3_y", y, 32'h0006_0000);
        @(negedge clock);
        check("single_clear", {31'b0, ovalid}, 32'h0);
        check("single_hold_y", y, 32'h0006_0000);

        // Four beats of 1.0 * -0.5 = -2.0
        for (int i = 0; i < 3; i++) begin
            beat(32'h0001_0000, 32'hFFFF_8000, 1'b0);
            check("vec4_noearly", {31'b0, ovalid}, 32'h0);
        end
        beat(32'h0001_0000, 32'hFFFF_8000, 1'b1);
        check("vec4_noearly_last", {31'b0, ovalid}, 32'h0);
        expect_result("vec4", 32'hFFFE_0000);

        // Saturation high and low
        beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        beat(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        expect_result("sat_max", 32'h7FFF_FFFF);
        beat(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        beat(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        expect_result("sat_min", 32'h8000_0000);

        // Round half up on both signs
        beat(32'h0000_0001, 32'h0000_8000, 1'b1);
        expect_result("round_pos", 32'h0000_0001);
        beat(32'hFFFF_FFFF, 32'h0000_8000, 1'b1);
        expect_result("round_neg", 32'h0000_0000);

        // Back-to-back vectors without a gap: 0.5*1.0 then -1.0*1.0
        beat(32'h0000_8000, 32'h0001_0000, 1'b1);
        beat(32'hFFFF_0000, 32'h0001_0000, 1'b1);
        expect_result("b2b_a", 32'h0000_8000);
        check("b2b_b_y", y, 32'hFFFF_0000);
        check("b2b_b_ovalid", {31'b0, ovalid}, 32'h1);
        @(negedge clock);

        // Backpressure
        oready = 1'b0;
        beat(32'h0001_0000, 32'h0001_0000, 1'b1);
        beat(32'h0002_0000, 32'h0001_0000, 1'b1);
        expect_result("bp_first", 32'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            check("bp_iready", {31'b0, iready}, 32'h0);
            check("bp_hold_y", y, 32'h0001_0000);
            check("bp_hold_ovalid", {31'b0, ovalid}, 32'h1);
            @(negedge clock);
        end
        check("bp_hold_y_last", y, 32'h0001_0000);
        oready = 1'b1;
        @(negedge clock);
        check("bp_second_y", y, 32'h0002_0000);
        check("bp_second_ovalid", {31'b0, ovalid}, 32'h1);
        @(negedge clock);
        check("bp_drain", {31'b0, ovalid}, 32'h0);
        check("bp_iready_back", {31'b0, iready}, 32'h1);

        // Reset mid-vector
        beat(32'h0001_0000, 32'h0001_0000, 1'b0);
        beat(32'h0001_0000, 32'h0001_0000, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_y", y, 32'h0);
        check("mid_rst_ovalid", {31'b0, ovalid}, 32'h0);
        check("mid_rst_iready", {31'b0, iready}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        beat(32'h0001_0000, 32'h0001_0000, 1'b1);
        expect_result("post_rst", 32'h0001_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dot_accumulate.md
Name: dot_accumulate

Overview:
- Streaming fixed-point multiply-accumulate stage that sits directly upstream of the ReLU activation block.
- Takes element pairs (x, w) in signed Q16.16 and accumulates their products over a vector delimited by ilast.
- At the end of each vector it emits one rounded, saturated signed Q16.16 dot-product result y; y feeds the ReLU input x.
- Pipelined at one beat per cycle, with valid/ready handshakes on input and output.

Parameters:
DATA_W, 32, width of x, w and y (signed two's complement)
FRAC_W, 16, fractional bits of x, w and y (Q16.16)
ACC_W, 80, accumulator width; guard bits cover up to 2^16 terms without wrap

Ports:
clock  input  1  single clock, rising edge
resetn  input  1  asynchronous active-low reset
x  input  DATA_W  vector element, signed Q16.16
w  input  DATA_W  weight element, signed Q16.16
ilast  input  1  marks final element of current vector
ivalid  input  1  x/w/ilast valid
iready  output  1  block can accept a beat this cycle
y  output  DATA_W  dot-product result, signed Q16.16, to ReLU x
ovalid  output  1  y valid
oready  input  1  downstream accepts y

Behaviour:
- Reset is asynchronous and active-low on resetn; the block has one clock, clock. While resetn=0: y=0, ovalid=0, all internal valid flags and accumulator cleared, first=1. iready is 0 during reset.
- Beat accepted on a rising edge when ivalid && iready.
- Global stall: stall = ovalid && !oready. iready = !stall. While stalled, every pipeline register holds its value, including the accumulator.
- Stage P (edge after accept):
  - p = x*w, full 2*DATA_W signed product (Q32.32).
  - p_valid and p_last registered with it.
- Stage A (next edge, if p_valid and !stall):
  - sum = (first ? 0 : acc) + sign-extended p, computed at ACC_W.
  - If !p_last: acc <= sum, first <= 0.
  - If p_last: s <= sum, s_valid <= 1, acc <= 0, first <= 1.
  - If no p_last this edge, s_valid <= 0.
- Stage O (next edge, if s_valid and !stall):
  - Round half up: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W.
  - Saturate to DATA_W signed: >0x7FFFFFFF gives 0x7FFFFFFF; <0x80000000 gives 0x80000000.
  - Load y, set ovalid=1.
- ovalid clears on an edge with ovalid && oready unless a new result loads on the same edge; then y updates and ovalid stays 1.
- Latency: beat with ilast accepted at edge k gives ovalid=1 after edge k+3 (no stall).
- Throughput: one beat per cycle with oready=1; back-to-back vectors need no gap.
- Single-element vector (ilast on first beat) is legal: y = round_sat(x*w).
- y holds its last value while ovalid=0.
- Accumulator wrap beyond 2^16 terms is unchecked and wraps modulo 2^ACC_W; saturation is applied only at the output.
- Reset mid-vector discards the partial sum. The first post-reset beat starts a new vector.
- ivalid without a later ilast accumulates indefinitely; no timeout.

Decomposition:
- Shared package (relu_pkg, shared with the activation blocks):
  - constants DATA_W, FRAC_W, ACC_W
  - Q16.16 limits SAT_MAX = 32'h7FFFFFFF, SAT_MIN = 32'h80000000
  - ROUND_HALF = 2^(FRAC_W-1)
- One combinational sub-module, q_round_sat: ACC_W input to DATA_W output, does round half up and saturation. It is reused by later activation/normalisation stages.

Test Plan:
- Single beat: x=0x00020000, w=0x00030000, ilast=1 → after 3 edges, ovalid=1, y=0x00060000.
- Four-beat vector: x=0x00010000, w=0xFFFF8000 each, ilast on beat 4 → one result, y=0xFFFE0000. No ovalid before beat 4 completes.
- Saturation:
  - Two beats x=w=0x7FFFFFFF → y=0x7FFFFFFF.
  - Two beats x=0x7FFFFFFF, w=0x80000000 → y=0x80000000.
- Rounding:
  - x=0x00000001, w=0x00008000, ilast → y=0x00000001.
  - x=0xFFFFFFFF, w=0x00008000, ilast → y=0x00000000.
- Backpressure: two single-beat vectors back-to-back (results 0x00010000, 0x00020000) with oready=0 for 5 cycles:
  - iready=0 while ovalid && !oready.
  - y=0x00010000 held stable.
  - After oready=1: 0x00010000 then 0x00020000 on consecutive cycles; no loss or duplication.
- Reset mid-vector: accept 2 beats of 0x00010000*0x00010000, pulse resetn low asynchronously → y=0, ovalid=0 immediately. Then one beat 0x00010000*0x00010000 with ilast → y=0x00010000, with no residue from the earlier beats.
